// File: rtl/lfsr_prng_pkg.sv
// Shared types and constants for the lfsr_prng block: FSM encoding, default tap
// masks and the step-counter width helper.
package lfsr_prng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    VALID = 2'd2
  } fsm_t;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hA3000000;

  // Counter must hold values 0..STEPS.
  function automatic int cnt_width(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/lfsr_prng_step.sv
// One Fibonacci LFSR shift: feedback is the XOR of the tapped state bits,
// shifted in at bit 0.
module lfsr_prng_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised LFSR pseudo-random generator with seed load and valid/ready output.
// Optional period detector enabled by defining LFSR_PRNG_PERIOD_CHK_EN.
module lfsr_prng
  import lfsr_prng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       fsm_state
`ifdef LFSR_PRNG_PERIOD_CHK_EN
  ,
  output logic             period_wrap
`endif
);

  // Handshake: a draw is transferred on a rising clk edge where out_valid and
  // out_ready are both high and seed_load is low; out_data is stable while
  // out_valid is high, and out_ready is ignored while out_valid is low.

  localparam int            CW   = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  fsm_t             fsm;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  logic [WIDTH-1:0] eff_seed;

  lfsr_prng_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .cur (state),
    .nxt (state_nxt)
  );

  // An all-zero seed would lock the register, so it is replaced by 1.
  assign eff_seed = (seed_in == '0) ? WIDTH'(1) : seed_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED_DEFAULT;
      fsm       <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (seed_load) begin
      state     <= eff_seed;
      fsm       <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (en) begin
            fsm  <= SHIFT;
            busy <= 1'b1;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          state <= state_nxt;
          if (cnt == LAST) begin
            fsm       <= VALID;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (en) begin
              fsm  <= SHIFT;
              busy <= 1'b1;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm       <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = state;
  assign fsm_state = fsm;

`ifdef LFSR_PRNG_PERIOD_CHK_EN
  logic [WIDTH-1:0] ref_seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_seed <= SEED_DEFAULT;
    end else if (seed_load) begin
      ref_seed <= eff_seed;
    end
  end

  assign period_wrap = out_valid && (state == ref_seed);
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: STEPS=1 and STEPS=4 instances (plus a
// WIDTH=8 period-check instance when LFSR_PRNG_PERIOD_CHK_EN is defined).
module tb_lfsr_prng;
  import lfsr_prng_pkg::*;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  logic        en1 = 0, ld1 = 0, rdy1 = 0, v1, b1;
  logic [15:0] seed1 = 0, d1;
  logic [1:0]  f1;
  logic        en4 = 0, ld4 = 0, rdy4 = 0, v4, b4;
  logic [15:0] seed4 = 0, d4;
  logic [1:0]  f4;
`ifdef LFSR_PRNG_PERIOD_CHK_EN
  logic        pw1, pw4, pw8;
  logic        en8 = 0, ld8 = 0, rdy8 = 0, v8, b8;
  logic [7:0]  seed8 = 0, d8;
  logic [1:0]  f8;
`endif

  lfsr_prng #(.WIDTH(16), .TAPS(16'hB400), .STEPS(1), .SEED_DEFAULT(16'h0001)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .seed_load(ld1), .seed_in(seed1),
    .out_valid(v1), .out_ready(rdy1), .out_data(d1), .busy(b1), .fsm_state(f1)
`ifdef LFSR_PRNG_PERIOD_CHK_EN
    , .period_wrap(pw1)
`endif
  );

  lfsr_prng #(.WIDTH(16), .TAPS(16'hB400), .STEPS(4), .SEED_DEFAULT(16'h0001)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .seed_load(ld4), .seed_in(seed4),
    .out_valid(v4), .out_ready(rdy4), .out_data(d4), .busy(b4), .fsm_state(f4)
`ifdef LFSR_PRNG_PERIOD_CHK_EN
    , .period_wrap(pw4)
`endif
  );

`ifdef LFSR_PRNG_PERIOD_CHK_EN
  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .STEPS(1), .SEED_DEFAULT(8'h01)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .seed_load(ld8), .seed_in(seed8),
    .out_valid(v8), .out_ready(rdy8), .out_data(d8), .busy(b8), .fsm_state(f8),
    .period_wrap(pw8)
  );
`endif

  // ---------------- reference model ----------------
  // Advance a w-bit LFSR n times: new bit 0 = parity of tapped bits.
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input logic [31:0] taps,
                                           input int w, input int n);
    logic [31:0] x = s;
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < n; i++) begin
      x = ((x << 1) | 32'($countones(x & taps) % 2)) & mask;
    end
    return x;
  endfunction

  function automatic logic [15:0] adv16(input logic [15:0] s, input int n);
    return 16'(lfsr_adv({16'h0, s}, 32'h0000_B400, 16, n));
  endfunction

  function automatic logic [15:0] eff(input logic [15:0] s);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  // ---------------- driver helper ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++; if (d1 !== 16'h0001) begin errors++; $display("FAIL reset_data1: got %h expected 0001", d1); end
    vectors++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", v1); end
    vectors++; if (b1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", b1); end
    vectors++; if (f1 !== IDLE) begin errors++; $display("FAIL reset_fsm1: got %0d expected %0d", f1, IDLE); end
    vectors++; if (d4 !== 16'h0001) begin errors++; $display("FAIL reset_data4: got %h expected 0001", d4); end
    vectors++; if (v4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b expected 0", v4); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] m = 16'h0001;
    logic [15:0] e;
    int draws = 0;
    int last_cyc = 0;
    logic pv = 1'b0;
    for (int i = 0; i < 11; i++) begin
      m = adv16(m, 1);
      exp_q.push_back(m);
    end
    en1 = 1; rdy1 = 1;
    for (int cyc = 1; cyc <= 40 && draws < 11; cyc++) begin
      tick();
      vectors++; if (b1 !== !v1) begin errors++; $display("FAIL stream_busy: cyc %0d busy %b valid %b expected busy=!valid", cyc, b1, v1); end
      if (v1 && !pv) begin
        draws++;
        e = exp_q.pop_front();
        vectors++; if (d1 !== e) begin errors++; $display("FAIL stream_draw%0d: got %h expected %h", draws, d1, e); end
        vectors++;
        if (draws == 1 && cyc != 2) begin errors++; $display("FAIL stream_first_latency: got %0d expected 2", cyc); end
        else if (draws > 1 && cyc - last_cyc != 2) begin errors++; $display("FAIL stream_interval: got %0d expected 2", cyc - last_cyc); end
        if (draws == 10) begin
          vectors++; if (d1 !== 16'h0400) begin errors++; $display("FAIL stream_draw10_const: got %h expected 0400", d1); end
        end
        if (draws == 11) begin
          vectors++; if (d1 !== 16'h0801) begin errors++; $display("FAIL stream_draw11_const: got %h expected 0801", d1); end
          en1 = 0;
        end
        last_cyc = cyc;
      end
      pv = v1;
    end
    vectors++; if (draws != 11) begin errors++; $display("FAIL stream_timeout: got %0d draws expected 11", draws); end
    tick();
    rdy1 = 0;
    vectors++; if (f1 !== IDLE) begin errors++; $display("FAIL stream_idle: got %0d expected %0d", f1, IDLE); end
  endtask

  task automatic test_hold();
    int busy_cnt = 0;
    logic got = 1'b0;
    en4 = 1; rdy4 = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (b4) busy_cnt++;
      if (v4) got = 1'b1;
    end
    en4 = 0;
    vectors++; if (!got) begin errors++; $display("FAIL hold_timeout: valid %b expected 1", v4); end
    vectors++; if (busy_cnt != 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", busy_cnt); end
    vectors++; if (d4 !== adv16(16'h0001, 4) || d4 !== 16'h0010) begin errors++; $display("FAIL hold_data: got %h expected 0010", d4); end
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++; if (v4 !== 1'b1 || d4 !== 16'h0010) begin errors++; $display("FAIL hold_stable: cyc %0d valid %b data %h expected 1/0010", i, v4, d4); end
    end
    rdy4 = 1;
    tick();
    rdy4 = 0;
    vectors++; if (v4 !== 1'b0 || f4 !== IDLE) begin errors++; $display("FAIL hold_release: valid %b fsm %0d expected 0/%0d", v4, f4, IDLE); end
  endtask

  task automatic test_en_drop();
    logic got = 1'b0;
    logic [15:0] e = adv16(16'h0010, 4);
    en4 = 1;
    tick();
    vectors++; if (b4 !== 1'b1) begin errors++; $display("FAIL endrop_shift: busy %b expected 1", b4); end
    tick();
    en4 = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (v4) got = 1'b1;
    end
    vectors++; if (!got) begin errors++; $display("FAIL endrop_timeout: valid %b expected 1", v4); end
    vectors++; if (d4 !== e) begin errors++; $display("FAIL endrop_data: got %h expected %h", d4, e); end
    rdy4 = 1;
    tick();
    rdy4 = 0;
    vectors++; if (v4 !== 1'b0 || f4 !== IDLE || b4 !== 1'b0) begin errors++; $display("FAIL endrop_idle: valid %b fsm %0d busy %b expected 0/%0d/0", v4, f4, b4, IDLE); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (d4 !== e || b4 !== 1'b0) begin errors++; $display("FAIL endrop_noshift: data %h busy %b expected %h/0", d4, b4, e); end
    end
  endtask

  task automatic test_seed_load();
    logic got;
    en1 = 1; rdy1 = 0;
    tick();
    vectors++; if (b1 !== 1'b1) begin errors++; $display("FAIL seed_shift: busy %b expected 1", b1); end
    ld1 = 1; seed1 = 16'h0000; en1 = 0;
    tick();
    ld1 = 0;
    vectors++; if (d1 !== 16'h0001) begin errors++; $display("FAIL seed_zero_data: got %h expected 0001", d1); end
    vectors++; if (v1 !== 1'b0 || f1 !== IDLE || b1 !== 1'b0) begin errors++; $display("FAIL seed_zero_state: valid %b fsm %0d busy %b expected 0/%0d/0", v1, f1, b1, IDLE); end
    en1 = 1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin tick(); if (v1) got = 1'b1; end
    vectors++; if (!got || d1 !== adv16(16'h0001, 1)) begin errors++; $display("FAIL seed_first_draw: valid %b data %h expected 1/%h", v1, d1, adv16(16'h0001, 1)); end
    ld1 = 1; seed1 = 16'hACE1; rdy1 = 1;
    tick();
    ld1 = 0; rdy1 = 0; en1 = 0;
    vectors++; if (d1 !== 16'hACE1) begin errors++; $display("FAIL seed_ace1_data: got %h expected ace1", d1); end
    vectors++; if (v1 !== 1'b0 || f1 !== IDLE) begin errors++; $display("FAIL seed_ace1_state: valid %b fsm %0d expected 0/%0d", v1, f1, IDLE); end
    en1 = 1; rdy1 = 1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin tick(); if (v1) got = 1'b1; end
    en1 = 0;
    vectors++; if (!got || d1 !== adv16(16'hACE1, 1)) begin errors++; $display("FAIL seed_after_ace1: valid %b data %h expected 1/%h", v1, d1, adv16(16'hACE1, 1)); end
    tick();
    rdy1 = 0;
  endtask

  task automatic test_random();
    logic [15:0] m = 16'h0;
    logic [15:0] hold = 16'h0;
    logic [15:0] sp = 16'h0;
    logic        lp = 1'b0;
    logic        pv = 1'b0;
    int          run = 0;
    for (int c = 0; c < 600; c++) begin
      ld4   = (c == 0) || ($urandom_range(0, 24) == 0);
      seed4 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      en4   = ($urandom_range(0, 3) != 0);
      rdy4  = ($urandom_range(0, 1) == 1);
      lp = ld4; sp = seed4;
      tick();
      if (lp) begin
        m = eff(sp); run = 0;
        vectors++; if (d4 !== m || v4 !== 1'b0 || b4 !== 1'b0) begin errors++; $display("FAIL rand_load: data %h valid %b busy %b expected %h/0/0", d4, v4, b4, m); end
      end else begin
        if (b4) run++;
        if (v4 && !pv) begin
          m = adv16(m, 4);
          hold = m;
          vectors++; if (d4 !== m) begin errors++; $display("FAIL rand_draw: got %h expected %h", d4, m); end
          vectors++; if (run != 4) begin errors++; $display("FAIL rand_latency: got %0d expected 4", run); end
          run = 0;
        end else if (v4 && pv) begin
          vectors++; if (d4 !== hold) begin errors++; $display("FAIL rand_stable: got %h expected %h", d4, hold); end
        end else if (!b4) begin
          vectors++; if (d4 !== m) begin errors++; $display("FAIL rand_idle: got %h expected %h", d4, m); end
        end
      end
      pv = v4;
    end
    ld4 = 0; en4 = 0; rdy4 = 0;
  endtask

  task automatic test_reset_mid();
    logic got = 1'b0;
    en1 = 1; rdy1 = 1;
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (d1 !== 16'h0001 || v1 !== 1'b0 || b1 !== 1'b0 || f1 !== IDLE) begin errors++; $display("FAIL reset_mid: data %h valid %b busy %b fsm %0d expected 0001/0/0/%0d", d1, v1, b1, f1, IDLE); end
    vectors++; if (d4 !== 16'h0001) begin errors++; $display("FAIL reset_mid_u4: got %h expected 0001", d4); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6 && !got; i++) begin tick(); if (v1) got = 1'b1; end
    vectors++; if (!got || d1 !== 16'h0002) begin errors++; $display("FAIL reset_mid_redraw: valid %b data %h expected 1/0002", v1, d1); end
    en1 = 0;
    tick();
    rdy1 = 0;
  endtask

`ifdef LFSR_PRNG_PERIOD_CHK_EN
  task automatic test_period();
    logic [7:0] m = 8'h01;
    logic       pv = 1'b0;
    int draws = 0;
    int first = 0;
    en8 = 1; rdy8 = 1;
    for (int c = 0; c < 700 && first == 0; c++) begin
      tick();
      if (v8 && !pv) begin
        draws++;
        m = 8'(lfsr_adv({24'h0, m}, 32'h0000_00B8, 8, 1));
        vectors++; if (d8 !== m) begin errors++; $display("FAIL period_draw%0d: got %h expected %h", draws, d8, m); end
        vectors++; if (pw8 !== (m == 8'h01)) begin errors++; $display("FAIL period_wrap%0d: got %b expected %b", draws, pw8, (m == 8'h01)); end
        if (pw8 === 1'b1) first = draws;
      end else begin
        vectors++; if (pw8 !== 1'b0) begin errors++; $display("FAIL period_wrap_idle: got %b expected 0", pw8); end
      end
      pv = v8;
    end
    en8 = 0;
    vectors++; if (first != 255 || d8 !== 8'h01) begin errors++; $display("FAIL period_first: draw %0d data %h expected 255/01", first, d8); end
    tick();
    rdy8 = 0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_en_drop();
    test_seed_load();
    test_random();
`ifdef LFSR_PRNG_PERIOD_CHK_EN
    test_period();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prng.md
Name: lfsr_prng

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator: configurable width, tap mask and shifts per draw.
- Adds a runtime seed-load port and a valid/ready output handshake.
- Feeds randomised scheduling and obfuscation logic; one consumer per instance.

Parameters:
- WIDTH, 16, state and output width; legal range 3..32.
- TAPS, 16'hB400, feedback tap mask (bit i set = state[i] XORed into feedback); TAPS[WIDTH-1] must be 1.
- STEPS, 1, LFSR shifts per draw; legal range 1..255.
- SEED_DEFAULT, 1, state value after reset; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  permits starting a new draw.
- seed_load  in  1  single-cycle pulse; loads seed_in.
- seed_in  in  WIDTH  seed value.
- out_valid  out  1  out_data holds a completed draw.
- out_ready  in  1  consumer accepts the draw.
- out_data  out  WIDTH  drawn value (LFSR state).
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = SEED_DEFAULT, FSM = IDLE, step counter = 0.
  - out_valid = 0, busy = 0, out_data = SEED_DEFAULT.
- One shift:
  - fb = XOR-reduce(state & TAPS).
  - state <= {state[WIDTH-2:0], fb}.
- out_data is wired to state. It is stable while out_valid = 1, because no shifts occur in VALID.
- FSM states:
  - IDLE: wait. If en = 1, go to SHIFT next cycle; the counter is cleared.
  - SHIFT: busy = 1; one shift per cycle; the counter increments each cycle. On the cycle performing shift number STEPS, go to VALID.
  - VALID: out_valid = 1. On out_ready = 1, the draw is consumed: go to SHIFT if en = 1, else IDLE.
  - Latency: out_valid rises exactly STEPS cycles after the first SHIFT cycle.
  - Throughput with continuous en and out_ready: one draw per STEPS+1 cycles.
- en deasserted mid-SHIFT: the current draw completes and is presented. en is sampled again only in IDLE and at VALID handshake.
- out_ready while out_valid = 0: ignored.
- seed_load = 1 (highest priority, any state):
  - state <= seed_in; if seed_in == 0, state <= 1 instead, to prevent lock-up.
  - FSM <= IDLE, counter cleared, out_valid <= 0.
  - Any pending draw is discarded.
  - seed_load together with out_ready in VALID: the load wins and the draw counts as not consumed.
- Counter width: clog2(STEPS+1) bits. No wrap occurs; it is cleared on leaving SHIFT.
- State never reaches 0 from a nonzero value for a primitive TAPS. No runtime check is performed outside the optional feature.

Optional Feature:
- Macro: LFSR_PRNG_PERIOD_CHK_EN.
- Defined:
  - Adds output port period_wrap (1 bit) and a WIDTH-bit reference register.
  - The reference register is loaded with the effective seed on reset or seed_load.
  - period_wrap = out_valid && (state == reference), i.e. the sequence has returned to its seed.
  - Reset value 0.
- Undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package lfsr_prng_pkg holds:
  - the FSM state enum (IDLE, SHIFT, VALID; 2-bit encoding);
  - the default tap constants TAPS_8 = 8'hB8, TAPS_16 = 16'hB400, TAPS_32 = 32'hA3000000;
  - a helper function computing the counter width.
- One natural sub-module: lfsr_prng_step, combinational. Parameters WIDTH and TAPS; maps state to next state. Reusable for future multi-step unrolling.

Test Plan:
- Reset release, WIDTH=16, TAPS=16'hB400, STEPS=1, en=1, out_ready=1 -> draws 0x0002, 0x0004, 0x0008; one draw every 2 cycles; busy toggles.
- Same config, 11 consecutive draws from seed 0x0001 -> 10th draw 0x0400, 11th draw 0x0801.
- STEPS=4, seed 0x0001, out_ready held 0 -> out_valid rises 4 cycles after SHIFT entry with out_data = 0x0010; held stable for 20 cycles until out_ready = 1.
- seed_load with seed_in = 0x0000 during SHIFT -> state = 0x0001, out_valid = 0, FSM IDLE next cycle. Repeat with seed_in = 0xACE1 in VALID while out_ready = 1 -> draw discarded, state = 0xACE1.
- en dropped on the 2nd of 4 SHIFT cycles -> draw still completes and is presented. After the handshake FSM returns to IDLE and no further shifts occur.
- With LFSR_PRNG_PERIOD_CHK_EN, WIDTH=16, STEPS=1 -> period_wrap asserts first on draw 65535 with out_data = 0x0001, and on no earlier draw. rst_n pulsed mid-run -> immediate return to 0x0001, IDLE, out_valid = 0.
